ahb_lite_result_writer: RTL and testbench

AHB_LITE_RESULT_WRITER -- requirements
Module: ahb_lite_result_writer

---
 rtl/ahb_lite_result_writer.sv | 133 +++++++++++++
 tb/tb_ahb_lite_result_writer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_result_writer.sv
// Drains a result FIFO into consecutive AHB-Lite single-beat word writes.
// One transfer is outstanding at a time: pop, load, address phase, data phase.
module ahb_lite_result_writer #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned ADDR_INC = 4
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] count,
   output logic             read_fifo_en,
   input  logic [31:0]      out_fifo,
   input  logic             empty,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic             HWRITE,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HMASTLOCK,
   output logic [31:0]      HWDATA,
   input  logic             HREADY,
   input  logic             HRESP,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam logic [1:0] TransIdle   = 2'b00;
   localparam logic [1:0] TransNonseq = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StLoad,
      StAddr,
      StData,
      StFin
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        haddr_q, haddr_d;
   logic [31:0]        data_q, data_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               done_q, done_d;
   logic               error_q, error_d;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q <= StIdle;
         addr_q  <= '0;
         haddr_q <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         haddr_q <= haddr_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      haddr_d      = haddr_q;
      data_d       = data_q;
      rem_d        = rem_q;
      done_d       = 1'b0;
      error_d      = 1'b0;
      read_fifo_en = 1'b0;
      HTRANS       = TransIdle;
      HWRITE       = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               addr_d  = base_addr;
               rem_d   = count;
               state_d = (count == '0) ? StFin : StPop;
            end
         end
         StPop: begin
            read_fifo_en = !empty;
            if (!empty) state_d = StLoad;
         end
         StLoad: begin
            // HADDR is a separate register so it keeps the last beat's address
            // after addr_q has advanced.
            data_d  = out_fifo;
            haddr_d = addr_q;
            state_d = StAddr;
         end
         StAddr: begin
            HTRANS = TransNonseq;
            HWRITE = 1'b1;
            if (HREADY) state_d = StData;
         end
         StData: begin
            if (HRESP) begin
               error_d = 1'b1;
               state_d = StIdle;
            end else if (HREADY) begin
               addr_d  = addr_q + ADDR_INC;
               rem_d   = rem_q - CNT_W'(1);
               state_d = (rem_q == CNT_W'(1)) ? StFin : StPop;
            end
         end
         StFin: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign HADDR     = haddr_q;
   assign HWDATA    = data_q;
   assign HSIZE     = 3'b010;
   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: tb/tb_ahb_lite_result_writer.sv
// Randomised bench: FIFO and AHB slave models feed the writer; the expected
// beat list is derived from base address, count and the words pushed.
module tb_ahb_lite_result_writer;

   localparam int unsigned CNT_W    = 16;
   localparam int unsigned ADDR_INC = 4;

   logic             HCLK = 1'b0;
   logic             HRESET = 1'b1;
   logic             start = 1'b0;
   logic [31:0]      base_addr = '0;
   logic [CNT_W-1:0] count = '0;
   logic             read_fifo_en;
   logic [31:0]      out_fifo = '0;
   logic             empty = 1'b1;
   logic [31:0]      HADDR;
   logic [1:0]       HTRANS;
   logic             HWRITE;
   logic [2:0]       HSIZE;
   logic [2:0]       HBURST;
   logic [3:0]       HPROT;
   logic             HMASTLOCK;
   logic [31:0]      HWDATA;
   logic             HREADY = 1'b1;
   logic             HRESP = 1'b0;
   logic             busy;
   logic             done;
   logic             error;

   ahb_lite_result_writer #(
      .CNT_W    (CNT_W),
      .ADDR_INC (ADDR_INC)
   ) dut (
      .HCLK         (HCLK),
      .HRESET       (HRESET),
      .start        (start),
      .base_addr    (base_addr),
      .count        (count),
      .read_fifo_en (read_fifo_en),
      .out_fifo     (out_fifo),
      .empty        (empty),
      .HADDR        (HADDR),
      .HTRANS       (HTRANS),
      .HWRITE       (HWRITE),
      .HSIZE        (HSIZE),
      .HBURST       (HBURST),
      .HPROT        (HPROT),
      .HMASTLOCK    (HMASTLOCK),
      .HWDATA       (HWDATA),
      .HREADY       (HREADY),
      .HRESP        (HRESP),
      .busy         (busy),
      .done         (done),
      .error        (error)
   );

   always #5 HCLK = ~HCLK;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference job: beat i goes to base + i*ADDR_INC carrying the i-th pushed word.
   logic [31:0] exp_addr [16];
   logic [31:0] exp_data [16];
   logic [31:0] fifo [$];
   logic [31:0] pop_data = '0;
   int cyc = 0, wcnt = 0, aw = 0, dw = 0, err_beat = 99, beat = 0;
   int n_addr = 0, beats_done = 0, pops = 0, n_done = 0, n_err = 0;
   int force_empty = 0, start_cyc = -1, done_cyc = -1;
   bit dphase = 1'b0, err_step = 1'b0, dph;

   // Slave/FIFO model: drive inputs on the falling edge, sample 1 time unit later.
   always begin
      @(negedge HCLK);
      cyc++;
      dph    = dphase;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (HRESET) begin
         dphase   = 1'b0;
         dph      = 1'b0;
         wcnt     = 0;
         err_step = 1'b0;
      end else if (dphase) begin
         if (beat == err_beat) begin
            HREADY = err_step;
            HRESP  = 1'b1;
            if (err_step) dphase = 1'b0;
            err_step = !err_step;
         end else if (wcnt < dw) begin
            HREADY = 1'b0;
            wcnt++;
         end
      end else if (HTRANS == 2'b10) begin
         if (wcnt < aw) begin
            HREADY = 1'b0;
            wcnt++;
         end
      end
      empty    = (force_empty > 0) || (fifo.size() == 0);
      out_fifo = pop_data;
      #1;
      if (!HRESET) begin
         if (HTRANS == 2'b10) begin
            check("haddr", HADDR, (n_addr < 16) ? exp_addr[n_addr] : 32'hDEAD_BEEF);
            check("hwrite", {31'b0, HWRITE}, 32'd1);
            if (HREADY) begin
               n_addr++;
               dphase = 1'b1;
               wcnt   = 0;
            end
         end
         if (dph) begin
            check("hwdata", HWDATA, exp_data[beat]);
            check("htrans_data", {30'b0, HTRANS}, 32'd0);
            if (HREADY && !HRESP) begin
               beats_done++;
               beat++;
               dphase = 1'b0;
               wcnt   = 0;
            end
         end
         if (read_fifo_en) begin
            pops++;
            check("pop_when_empty", {31'b0, empty}, 32'd0);
            if (fifo.size() > 0) pop_data = fifo.pop_front();
         end
         if (force_empty > 0) begin
            check("rd_en_while_empty", {31'b0, read_fifo_en}, 32'd0);
            check("htrans_while_empty", {30'b0, HTRANS}, 32'd0);
            force_empty--;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if (error) n_err++;
         if (start) start_cyc = cyc;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, ":haddr"}, HADDR, 32'd0);
      check({tag, ":htrans"}, {30'b0, HTRANS}, 32'd0);
      check({tag, ":hwrite"}, {31'b0, HWRITE}, 32'd0);
      check({tag, ":hwdata"}, HWDATA, 32'd0);
      check({tag, ":rd_en"}, {31'b0, read_fifo_en}, 32'd0);
      check({tag, ":busy"}, {31'b0, busy}, 32'd0);
      check({tag, ":done"}, {31'b0, done}, 32'd0);
      check({tag, ":error"}, {31'b0, error}, 32'd0);
   endtask

   task automatic prep_job(input logic [31:0] base, input int cnt, input int a_w, input int d_w,
                           input int e_b, input int f_e, input bit fixed);
      logic [31:0] w;
      @(posedge HCLK);
      #1;
      fifo.delete();
      n_addr = 0; beats_done = 0; pops = 0; n_done = 0; n_err = 0; beat = 0;
      start_cyc = -1; done_cyc = -1;
      for (int i = 0; i < cnt; i++) begin
         w = fixed ? 32'hA + 32'(i) : $urandom;
         fifo.push_back(w);
         exp_data[i] = w;
         exp_addr[i] = base + 32'(i) * ADDR_INC;
      end
      aw = a_w; dw = d_w; err_beat = e_b; force_empty = f_e;
      base_addr = base;
      count     = CNT_W'(cnt);
      start     = 1'b1;
      @(posedge HCLK);
      #1;
      start = 1'b0;
   endtask

   task automatic run_job(input string name, input logic [31:0] base, input int cnt,
                          input int a_w, input int d_w, input int e_b, input int f_e,
                          input bit fixed);
      int to, n_beats;
      bit aborted;
      prep_job(base, cnt, a_w, d_w, e_b, f_e, fixed);
      check({name, ":busy_after_start"}, {31'b0, busy}, 32'd1);
      to = 0;
      while (n_done == 0 && n_err == 0 && to < 2000) begin
         @(posedge HCLK);
         #1;
         to++;
      end
      check({name, ":completed_in_time"}, {31'b0, to < 2000}, 32'd1);
      repeat (4) @(posedge HCLK);
      #1;
      aborted = (e_b < cnt);
      n_beats = aborted ? e_b : cnt;
      check({name, ":beats"}, beats_done, n_beats);
      check({name, ":nonseq"}, n_addr, aborted ? e_b + 1 : cnt);
      check({name, ":pops"}, pops, aborted ? e_b + 1 : cnt);
      check({name, ":done_pulses"}, n_done, aborted ? 0 : 1);
      check({name, ":error_pulses"}, n_err, aborted ? 1 : 0);
      check({name, ":busy_end"}, {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int to, c, eb;
      logic [31:0] b;
      #1;
      check_reset_outputs("por");
      check("hsize", {29'b0, HSIZE}, 32'd2);
      check("hprot", {28'b0, HPROT}, 32'd3);
      check("hburst_lock", {28'b0, HBURST, HMASTLOCK}, 32'd0);
      repeat (3) @(posedge HCLK);
      #1;
      HRESET = 1'b0;

      run_job("basic", 32'h2000_0000, 3, 0, 0, 99, 0, 1'b1);
      run_job("waits", 32'h4000_0100, 2, 3, 3, 99, 0, 1'b0);
      run_job("err_beat2", 32'h3000_0000, 4, 0, 0, 1, 0, 1'b0);
      run_job("zero", 32'h5000_0000, 0, 0, 0, 99, 0, 1'b0);
      check("zero:done_latency", done_cyc - start_cyc, 32'd2);
      run_job("empty_hold", 32'h6000_0040, 3, 0, 0, 99, 10, 1'b0);
      run_job("wrap", 32'hFFFF_FFFC, 2, 0, 1, 99, 0, 1'b0);

      for (int j = 0; j < 12; j++) begin
         b  = {$urandom, 2'b00};
         c  = $urandom_range(5, 1);
         eb = ($urandom_range(3, 0) == 0) ? $urandom_range(c - 1, 0) : 99;
         run_job("rand", b, c, $urandom_range(2, 0), $urandom_range(2, 0), eb,
                 ($urandom_range(3, 0) == 0) ? $urandom_range(5, 1) : 0, 1'b0);
      end

      // Reset during a data phase must clear outputs without a clock edge.
      prep_job(32'h7000_0000, 3, 0, 3, 99, 0, 1'b0);
      to = 0;
      while (!dphase && to < 100) begin
         @(posedge HCLK);
         #1;
         to++;
      end
      check("rst:reached_data", {31'b0, dphase}, 32'd1);
      #2;
      HRESET = 1'b1;
      #1;
      check_reset_outputs("rst_async");
      repeat (2) @(posedge HCLK);
      #1;
      HRESET = 1'b0;
      n_addr = 0;
      pops   = 0;
      repeat (10) @(posedge HCLK);
      #1;
      check("rst:no_nonseq_after", n_addr, 32'd0);
      check("rst:no_pops_after", pops, 32'd0);
      check("rst:idle_after", {31'b0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
